// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART.
// Oversamples the 8N1 serial line on the shared baud tick, reassembles bytes
// LSB first and presents them to the bus with rda / framing_err / overrun.
//
// Bus handshake: rda is the "valid" flag for rx_data. The bus acknowledges a
// byte by pulsing clr_rda for one cycle; rda, framing_err and overrun drop on
// the following clk edge. A byte completing in the same cycle as clr_rda takes
// priority, so the new byte is never lost.
//
// state_dbg encoding: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK.

module spart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic       rxd,
    input  logic       clr_rda,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);

    // Tick count that marks the middle of the start bit, counted from the
    // tick that first saw the line low.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    // Tick count that marks one full bit period after the previous sample.
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            rxd_meta_q, rxd_meta_d;
    logic            rxd_sync_q, rxd_sync_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rda_q, rda_d;
    logic            framing_err_q, framing_err_d;
    logic            overrun_q, overrun_d;
    logic            rxd_s;

    assign rxd_s = rxd_sync_q;

    // Next-state logic: synchronizer, bus acknowledge, and the bit-level FSM.
    always_comb begin
        rxd_meta_d    = rxd;
        rxd_sync_d    = rxd_meta_q;
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rda_d         = rda_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;

        // Acknowledge from the bus; a completion below overrides it.
        if (clr_rda) begin
            rda_d         = 1'b0;
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end

        if (baud_clk) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end

                S_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        if (!rxd_s) begin
                            state_d   = S_DATA;
                            bit_cnt_d = 4'd0;
                        end else begin
                            // Line came back high before mid start bit: noise.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end

                S_DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        // New bit enters at the top so LSB-first data ends aligned.
                        shift_d    = {rxd_s, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end

                S_STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d    = '0;
                        rx_data_d     = shift_q;
                        rda_d         = 1'b1;
                        framing_err_d = !rxd_s;
                        // Previous byte unread and not being read right now.
                        overrun_d     = overrun_d | (rda_q & ~clr_rda);
                        state_d       = rxd_s ? S_IDLE : S_BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end

                S_BREAK: begin
                    // Wait out a held-low line so it reports only one byte.
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = 4'd0;
                end
            endcase
        end
    end

    // State register with synchronous reset; synchronizer resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rxd_meta_q    <= 1'b1;
            rxd_sync_q    <= 1'b1;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rxd_meta_q    <= rxd_meta_d;
            rxd_sync_q    <= rxd_sync_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: frame-level bench for spart_rx.
// Drives 8N1 frames tick by tick and compares the bus-side flags against a
// byte-level model of what the receiver should report.

module tb_spart_rx;

    localparam int OS = 16;
    // Debug state encoding of the receiver FSM.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;
    // Stop sample tick, counting from the tick after which the start bit is driven:
    // detection 1 tick later, then half a bit, then 9 full bits.
    localparam int STOP_TICK = 1 + OS / 2 + 9 * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_clk;
    logic       rxd = 1'b1;
    logic       clr_rda = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    // Reference model of the bus-visible registers.
    logic [7:0] exp_q[$];
    logic [7:0] m_data = 8'h00;
    logic       m_rda = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;
    logic [10:0] obs, exp_v;
    int         rise;

    // Clock and baud tick: baud_clk is high one clk cycle in four.
    logic [1:0] div_q = 2'd0;
    always #5 clk = ~clk;
    always @(posedge clk) div_q <= div_q + 2'd1;
    assign baud_clk = (div_q == 2'd3);

    spart_rx #(.OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_clk    (baud_clk),
        .rxd         (rxd),
        .clr_rda     (clr_rda),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun),
        .state_dbg   (state_dbg)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic void model_complete(input logic stop_bit, input logic clr_same);
        m_data = exp_q.pop_front();
        m_ov   = clr_same ? 1'b0 : (m_ov | m_rda);
        m_rda  = 1'b1;
        m_fe   = !stop_bit;
    endfunction

    function automatic void model_clear();
        m_rda = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_data = 8'h00;
    endfunction

    // ---------------- drivers ----------------
    // Returns 1 time unit after the next clk edge that samples baud_clk high;
    // clr_rda can be pulsed exactly on that edge.
    task automatic wait_tick(input logic clr);
        @(negedge clk);
        while (!baud_clk) @(negedge clk);
        clr_rda = clr;
        @(posedge clk);
        #1;
        clr_rda = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick(1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rda = 1'b1;
        @(posedge clk);
        #1;
        clr_rda = 1'b0;
    endtask

    // Sends one frame; tick t counts from the aligned tick before the start bit.
    // clr_tick / rst_tick place a pulse on that tick edge (-1 = none); a reset
    // aborts the frame. rise_tick reports the first tick after which rda rose.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int stop_ticks, input int clr_tick,
                              input int rst_tick, output int rise_tick);
        int   t;
        int   len;
        logic prev;
        t = 0;
        rise_tick = -1;
        wait_tick(1'b0);
        prev = rda;
        for (int b = 0; b < 10; b++) begin
            if (b == 0) rxd = 1'b0;
            else if (b == 9) rxd = stop_bit;
            else rxd = data[b-1];
            len = (b == 9) ? stop_ticks : OS;
            for (int k = 0; k < len; k++) begin
                t++;
                wait_tick(t == clr_tick);
                if (t == rst_tick) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    return;
                end
                if (rda && !prev && rise_tick < 0) rise_tick = t;
                prev = rda;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_reset();
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_frame: got %h expected %h", obs, exp_v);
        end
        checks++;
        if (rise !== STOP_TICK) begin
            failures++;
            $display("FAIL basic_rda_timing: got tick %0d expected tick %0d", rise, STOP_TICK);
        end
        pulse_clr();
        model_clear();
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_glitch();
        logic saw_start;
        logic saw_beyond;
        saw_start = 1'b0;
        saw_beyond = 1'b0;
        wait_tick(1'b0);
        rxd = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (k == 3) rxd = 1'b1;
            wait_tick(1'b0);
            if (state_dbg === ST_START) saw_start = 1'b1;
            if (state_dbg === ST_DATA || state_dbg === ST_STOP || state_dbg === ST_BREAK)
                saw_beyond = 1'b1;
        end
        checks++;
        if (saw_start !== 1'b1) begin
            failures++;
            $display("FAIL glitch_detect: start seen %b expected 1", saw_start);
        end
        checks++;
        if (saw_beyond !== 1'b0) begin
            failures++;
            $display("FAIL glitch_beyond_start: got %b expected 0", saw_beyond);
        end
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v || state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL glitch_outputs: got %h state %0d expected %h state %0d",
                     obs, state_dbg, exp_v, ST_IDLE);
        end
    endtask

    task automatic test_break();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 40, -1, -1, rise);
        model_complete(1'b0, 1'b0);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v || rise !== STOP_TICK) begin
            failures++;
            $display("FAIL break_frame: got %h at tick %0d expected %h at tick %0d",
                     obs, rise, exp_v, STOP_TICK);
        end
        checks++;
        if (state_dbg !== ST_BREAK) begin
            failures++;
            $display("FAIL break_state: got %0d expected %0d", state_dbg, ST_BREAK);
        end
        pulse_clr();
        model_clear();
        wait_ticks(20);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v || state_dbg !== ST_BREAK) begin
            failures++;
            $display("FAIL break_single: got %h state %0d expected %h state %0d",
                     obs, state_dbg, exp_v, ST_BREAK);
        end
        rxd = 1'b1;
        wait_ticks(2);
        checks++;
        if (state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL break_exit: got %0d expected %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL overrun_set: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        model_clear();
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL overrun_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_clr_coincide();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, OS, STOP_TICK, -1, rise);
        model_complete(1'b1, 1'b1);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL clr_coincide: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        model_clear();
    endtask

    task automatic test_reset_midframe();
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        // Tick 88 lies inside data bit 4 (bit periods begin every 16 ticks).
        send_frame(8'hC3, 1'b1, OS, -1, 5 * OS + 8, rise);
        model_reset();
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v || state_dbg !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_midframe: got %h state %0d expected %h state %0d",
                     obs, state_dbg, exp_v, ST_IDLE);
        end
        rxd = 1'b1;
        wait_ticks(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, OS, -1, -1, rise);
        model_complete(1'b1, 1'b0);
        obs = {rx_data, rda, framing_err, overrun};
        exp_v = {m_data, m_rda, m_fe, m_ov};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL after_reset_frame: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] data;
        logic       stop_bit;
        logic       clr_same;
        for (int i = 0; i < 10; i++) begin
            data     = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            clr_same = ($urandom_range(0, 3) == 0);
            exp_q.push_back(data);
            send_frame(data, stop_bit, OS, clr_same ? STOP_TICK : -1, -1, rise);
            model_complete(stop_bit, clr_same);
            obs = {rx_data, rda, framing_err, overrun};
            exp_v = {m_data, m_rda, m_fe, m_ov};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_frame_%0d: got %h expected %h", i, obs, exp_v);
            end
            if (!stop_bit) begin
                rxd = 1'b1;
                wait_ticks(2);
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                model_clear();
                obs = {rx_data, rda, framing_err, overrun};
                exp_v = {m_data, m_rda, m_fe, m_ov};
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random_clear_%0d: got %h expected %h", i, obs, exp_v);
                end
            end
            wait_ticks($urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_clr_coincide();
        test_reset_midframe();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
